// File: rtl/mem_ctrl.sv
// Serialises whole-request reads (1/2/4 bytes) and a byte write stream onto one byte-wide RAM/IO port.
// Latency: read accepted in cycle 0, r_done_o with assembled data in cycle len+1; writes issue in the accept cycle.
// Backpressure: r_wait_o/w_wait_o stay high through READ and DONE; a full IO buffer only lowers writting_o.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_i,
  input  logic        sign_i,
  input  logic [2:0]  len_i,
  input  logic [31:0] r_addr_i,
  output logic [31:0] r_data_o,
  output logic        r_done_o,
  output logic        r_wait_o,
  input  logic        write_i,
  input  logic [31:0] w_addr_i,
  input  logic [7:0]  w_data_i,
  output logic        w_wait_o,
  output logic        writting_o,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic [2:0]      len_q;
  logic            sign_q;
  logic [31:0]     addr_q;
  logic [3:0][7:0] buf_q;
  logic [3:0][7:0] buf_nxt;
  logic [31:0]     result;
  logic [1:0]      lane;
  logic            idle;
  logic            len_ok;
  logic            w_io;
  logic            rd_accept;

  assign idle       = (state == IDLE);
  assign len_ok     = (len_i == 3'd1) || (len_i == 3'd2) || (len_i == 3'd4);
  assign w_io       = (w_addr_i[17:16] == 2'b11);
  assign writting_o = write_i & idle & ~(w_io & io_buffer_full);
  // The write has priority: a simultaneous read is simply not accepted.
  assign rd_accept  = read_i & idle & ~write_i & len_ok;
  assign r_wait_o   = ~idle | write_i;
  assign w_wait_o   = ~idle;
  // In READ, cnt = k means byte k-1 is arriving on mem_din (cnt 4 wraps to lane 3).
  assign lane       = cnt[1:0] - 2'd1;

  // Buffer including the byte arriving this cycle, so the final byte can go straight into r_data_o.
  always_comb begin
    buf_nxt = buf_q;
    if (state == READ && cnt != 3'd0) begin
      buf_nxt[lane] = mem_din;
    end
  end

  // Assemble and optionally sign-extend according to the latched length.
  always_comb begin
    case (len_q)
      3'd4:    result = buf_nxt;
      3'd2:    result = {{16{sign_q & buf_nxt[1][7]}}, buf_nxt[1], buf_nxt[0]};
      default: result = {{24{sign_q & buf_nxt[0][7]}}, buf_nxt[0]};
    endcase
  end

  // Drive the byte port: accepted write, first read byte (from the request), later read bytes, else idle zeros.
  always_comb begin
    mem_a    = 32'd0;
    mem_wr   = 1'b0;
    mem_dout = 8'd0;
    if (writting_o) begin
      mem_a    = w_addr_i;
      mem_wr   = 1'b1;
      mem_dout = w_data_i;
    end else if (rd_accept) begin
      mem_a = r_addr_i;
    end else if (state == READ && cnt < len_q) begin
      mem_a = addr_q + {29'd0, cnt};
    end
  end

  // Read FSM: latch the request, collect bytes, register the result with a one-cycle done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      len_q    <= 3'd0;
      sign_q   <= 1'b0;
      addr_q   <= 32'd0;
      buf_q    <= '0;
      r_data_o <= 32'd0;
      r_done_o <= 1'b0;
    end else begin
      r_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_accept) begin
            state  <= READ;
            cnt    <= 3'd1;
            len_q  <= len_i;
            sign_q <= sign_i;
            addr_q <= r_addr_i;
          end
        end
        READ: begin
          buf_q <= buf_nxt;
          if (cnt == len_q) begin
            state    <= DONE;
            cnt      <= 3'd0;
            r_data_o <= result;
            r_done_o <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: IDLE-state vector table plus hand-written multi-cycle sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A small byte-RAM model answers reads one cycle after the address and records writes.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_i, sign_i;
  logic [2:0]  len_i;
  logic [31:0] r_addr_i;
  logic [31:0] r_data_o;
  logic        r_done_o, r_wait_o;
  logic        write_i;
  logic [31:0] w_addr_i;
  logic [7:0]  w_data_i;
  logic        w_wait_o, writting_o;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .read_i(read_i), .sign_i(sign_i), .len_i(len_i), .r_addr_i(r_addr_i),
    .r_data_o(r_data_o), .r_done_o(r_done_o), .r_wait_o(r_wait_o),
    .write_i(write_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .w_wait_o(w_wait_o), .writting_o(writting_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  logic [7:0] ram [logic [31:0]];

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    read_i = 0; sign_i = 0; len_i = 0; r_addr_i = 0;
    write_i = 0; w_addr_i = 0; w_data_i = 0; io_buffer_full = 0;
  endtask

  // Full read with cycle-accurate checks; done expected in cycle len+1.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] len,
                         input logic sgn, input logic [31:0] exp);
    int n;
    n = int'(len);
    tick();
    read_i = 1; sign_i = sgn; len_i = len; r_addr_i = addr;
    @(negedge clk);
    chk({tag, " c0 mem_a"}, mem_a, addr);
    chk({tag, " c0 mem_wr"}, {31'd0, mem_wr}, 32'd0);
    chk({tag, " c0 r_wait"}, {31'd0, r_wait_o}, 32'd0);
    for (int k = 1; k <= n + 2; k++) begin
      tick();
      if (k == 1) begin
        read_i = 0; sign_i = ~sgn; len_i = 0; r_addr_i = 32'hDEAD_0000;
      end
      @(negedge clk);
      if (k < n) chk($sformatf("%s c%0d mem_a", tag, k), mem_a, addr + k);
      else       chk($sformatf("%s c%0d mem_a idle", tag, k), mem_a, 32'd0);
      if (k == n + 1) begin
        chk($sformatf("%s c%0d r_done", tag, k), {31'd0, r_done_o}, 32'd1);
        chk($sformatf("%s c%0d r_data", tag, k), r_data_o, exp);
        chk($sformatf("%s c%0d r_wait", tag, k), {31'd0, r_wait_o}, 32'd1);
      end else if (k == n + 2) begin
        chk($sformatf("%s c%0d r_done low", tag, k), {31'd0, r_done_o}, 32'd0);
        chk($sformatf("%s c%0d r_wait low", tag, k), {31'd0, r_wait_o}, 32'd0);
        chk($sformatf("%s c%0d r_data hold", tag, k), r_data_o, exp);
      end else begin
        chk($sformatf("%s c%0d r_done", tag, k), {31'd0, r_done_o}, 32'd0);
        chk($sformatf("%s c%0d r_wait", tag, k), {31'd0, r_wait_o}, 32'd1);
        chk($sformatf("%s c%0d w_wait", tag, k), {31'd0, w_wait_o}, 32'd1);
      end
    end
    clear_inputs();
  endtask

  typedef struct packed {
    logic        rd;
    logic        sg;
    logic [2:0]  len;
    logic [31:0] raddr;
    logic        wr;
    logic [31:0] waddr;
    logic [7:0]  wdat;
    logic        full;
    logic [31:0] e_a;
    logic        e_wr;
    logic [7:0]  e_dout;
    logic        e_wing;
    logic        e_wwait;
    logic        e_rwait;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 3'd0, 32'h0,   1'b0, 32'h0,     8'h00, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 3'd0, 32'h0,   1'b1, 32'h40,    8'hAB, 1'b0, 32'h40,    1'b1, 8'hAB, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 3'd4, 32'h100, 1'b1, 32'h40,    8'hAB, 1'b0, 32'h40,    1'b1, 8'hAB, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 3'd3, 32'h100, 1'b0, 32'h0,     8'h00, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 3'd0, 32'h100, 1'b0, 32'h0,     8'h00, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 3'd0, 32'h0,   1'b1, 32'h30000, 8'h5A, 1'b1, 32'h0,     1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 32'h0,   1'b1, 32'h30000, 8'h5A, 1'b0, 32'h30000, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 3'd0, 32'h0,   1'b1, 32'h20000, 8'h11, 1'b1, 32'h20000, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 3'd2, 32'h100, 1'b1, 32'h10000, 8'h22, 1'b1, 32'h10000, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 3'd0, 32'h0,   1'b0, 32'h0,     8'h00, 1'b0, 32'h0,     1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h205] = 8'h80;
    ram[32'h300] = 8'h01; ram[32'h301] = 8'h80;
    ram[32'h400] = 8'h34; ram[32'h401] = 8'h12;

    rst = 0;
    clear_inputs();
    #2;
    chk("reset r_data", r_data_o, 32'd0);
    chk("reset r_done", {31'd0, r_done_o}, 32'd0);
    chk("reset r_wait", {31'd0, r_wait_o}, 32'd0);
    chk("reset w_wait", {31'd0, w_wait_o}, 32'd0);
    chk("reset mem_a", mem_a, 32'd0);
    chk("reset mem_wr", {31'd0, mem_wr}, 32'd0);
    @(posedge clk);
    #1 rst = 1;

    // IDLE vectors: each applied for one cycle; a wrongly accepted read shows up as r_wait in the next one.
    for (int i = 0; i < 10; i++) begin
      tick();
      read_i = vecs[i].rd; sign_i = vecs[i].sg; len_i = vecs[i].len; r_addr_i = vecs[i].raddr;
      write_i = vecs[i].wr; w_addr_i = vecs[i].waddr; w_data_i = vecs[i].wdat;
      io_buffer_full = vecs[i].full;
      @(negedge clk);
      chk($sformatf("vec%0d mem_a", i), mem_a, vecs[i].e_a);
      chk($sformatf("vec%0d mem_wr", i), {31'd0, mem_wr}, {31'd0, vecs[i].e_wr});
      chk($sformatf("vec%0d mem_dout", i), {24'd0, mem_dout}, {24'd0, vecs[i].e_dout});
      chk($sformatf("vec%0d writting", i), {31'd0, writting_o}, {31'd0, vecs[i].e_wing});
      chk($sformatf("vec%0d w_wait", i), {31'd0, w_wait_o}, {31'd0, vecs[i].e_wwait});
      chk($sformatf("vec%0d r_wait", i), {31'd0, r_wait_o}, {31'd0, vecs[i].e_rwait});
      chk($sformatf("vec%0d r_done", i), {31'd0, r_done_o}, 32'd0);
    end
    tick();
    clear_inputs();

    do_read("rd4", 32'h100, 3'd4, 1'b0, 32'h4433_2211);
    do_read("rd1s", 32'h205, 3'd1, 1'b1, 32'hFFFF_FF80);
    do_read("rd1u", 32'h205, 3'd1, 1'b0, 32'h0000_0080);
    do_read("rd2s", 32'h300, 3'd2, 1'b1, 32'hFFFF_8001);

    // Write raised in cycle 2 of a 4-byte read: blocked through cycle 5, issued in cycle 6.
    tick();
    read_i = 1; len_i = 3'd4; r_addr_i = 32'h100;
    @(negedge clk);
    chk("wdr c0 mem_a", mem_a, 32'h100);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin read_i = 0; len_i = 0; r_addr_i = 0; end
      if (c == 2) begin write_i = 1; w_addr_i = 32'h50; w_data_i = 8'hC3; end
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        chk($sformatf("wdr c%0d w_wait", c), {31'd0, w_wait_o}, 32'd1);
        chk($sformatf("wdr c%0d writting", c), {31'd0, writting_o}, 32'd0);
        chk($sformatf("wdr c%0d mem_wr", c), {31'd0, mem_wr}, 32'd0);
      end
      if (c == 5) begin
        chk("wdr c5 r_done", {31'd0, r_done_o}, 32'd1);
        chk("wdr c5 r_data", r_data_o, 32'h4433_2211);
      end
      if (c == 6) begin
        chk("wdr c6 writting", {31'd0, writting_o}, 32'd1);
        chk("wdr c6 mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("wdr c6 mem_a", mem_a, 32'h50);
        chk("wdr c6 mem_dout", {24'd0, mem_dout}, 32'hC3);
        chk("wdr c6 w_wait", {31'd0, w_wait_o}, 32'd0);
      end
    end
    tick();
    clear_inputs();
    chk("wdr ram byte", {24'd0, ram[32'h50]}, 32'hC3);

    // IO write stalled by a full buffer for three cycles, issued when it drains.
    for (int c = 0; c <= 3; c++) begin
      tick();
      write_i = 1; w_addr_i = 32'h30000; w_data_i = 8'h77; io_buffer_full = (c < 3);
      @(negedge clk);
      if (c < 3) begin
        chk($sformatf("io c%0d writting", c), {31'd0, writting_o}, 32'd0);
        chk($sformatf("io c%0d mem_wr", c), {31'd0, mem_wr}, 32'd0);
        chk($sformatf("io c%0d w_wait", c), {31'd0, w_wait_o}, 32'd0);
        chk($sformatf("io c%0d mem_a", c), mem_a, 32'd0);
      end else begin
        chk("io c3 writting", {31'd0, writting_o}, 32'd1);
        chk("io c3 mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("io c3 mem_a", mem_a, 32'h30000);
        chk("io c3 mem_dout", {24'd0, mem_dout}, 32'h77);
      end
    end
    tick();
    clear_inputs();

    // Reset in cycle 2 of a 4-byte read: outputs clear, no done pulse, next read is normal.
    tick();
    read_i = 1; len_i = 3'd4; r_addr_i = 32'h100;
    tick();
    clear_inputs();
    tick();
    #1 rst = 0;
    #1;
    chk("mrst r_wait", {31'd0, r_wait_o}, 32'd0);
    chk("mrst w_wait", {31'd0, w_wait_o}, 32'd0);
    chk("mrst mem_a", mem_a, 32'd0);
    chk("mrst r_data", r_data_o, 32'd0);
    chk("mrst r_done", {31'd0, r_done_o}, 32'd0);
    tick();
    rst = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("mrst after c%0d r_done", c), {31'd0, r_done_o}, 32'd0);
      chk($sformatf("mrst after c%0d r_wait", c), {31'd0, r_wait_o}, 32'd0);
      tick();
    end
    do_read("rd2post", 32'h400, 3'd2, 1'b0, 32'h0000_1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
